uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ byte-stream requesters.
- Grants the transmitter to one requester for a whole packet (bytes up to and including the last flag), using round-robin order.
- Optionally prepends a header byte that carries the requester ID.
- Sits upstream of the transmitter's FIFO write port. It obeys the FIFO threshold-full flag, so no byte is ever written while that flag is high.

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } arb_state_e;

   localparam logic [3:0] HDR_TAG = 4'hA;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          req,
   input  logic [clog2(NUM_REQ)-1:0]   ptr,
   output logic [NUM_REQ-1:0]          grant,
   output logic [clog2(NUM_REQ)-1:0]   grant_idx,
   output logic                        any_req
);

   localparam int IDX_W = clog2(NUM_REQ);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // ptr < NUM_REQ and i < NUM_REQ, so one conditional subtract is a full modulo.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
         cand = sum[IDX_W-1:0];
         if (!any_req && req[cand]) begin
            any_req     = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART transmitter FIFO,
// with an optional requester-ID header byte ahead of each packet.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HEADER_EN   = 1,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [8*NUM_REQ-1:0]   req_data_i,
   input  logic [NUM_REQ-1:0]     req_last_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic [7:0]             tx_data_o,
   output logic                   tx_write_o,
   input  logic                   tx_full_i,
   output logic [NUM_REQ-1:0]     grant_o,
   output logic                   busy_o
);

   localparam int IDX_W = clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]         byte_cnt_q, byte_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;

   logic [NUM_REQ-1:0] win_grant;
   logic [IDX_W-1:0]   win_idx;
   logic               any_req;
   logic [7:0]         owner_byte;
   logic               at_max;
   logic [IDX_W-1:0]   next_ptr;

   function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] idx);
      logic [3:0] id;
      id            = '0;
      id[IDX_W-1:0] = idx;
      return {HDR_TAG, id};
   endfunction

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req       (req_valid_i),
      .ptr       (rr_ptr_q),
      .grant     (win_grant),
      .grant_idx (win_idx),
      .any_req   (any_req)
   );

   assign owner_byte = req_data_i[{owner_q, 3'b000} +: 8];
   assign at_max     = (({1'b0, byte_cnt_q} + 9'd1) == 9'(MAX_PKT_LEN));
   assign next_ptr   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign grant_o    = grant_q;
   assign busy_o     = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      byte_cnt_d  = byte_cnt_q;
      grant_d     = grant_q;
      req_ready_o = '0;
      tx_write_o  = 1'b0;
      tx_data_o   = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d    = win_idx;
               grant_d    = win_grant;
               byte_cnt_d = '0;
               state_d    = (HEADER_EN != 0) ? HEADER : DATA;
            end
         end
         HEADER: begin
            if (!tx_full_i) begin
               tx_write_o = 1'b1;
               tx_data_o  = hdr_byte(owner_q);
               state_d    = DATA;
            end
         end
         DATA: begin
            req_ready_o = tx_full_i ? '0 : grant_q;
            if (req_valid_i[owner_q] && !tx_full_i) begin
               tx_write_o = 1'b1;
               tx_data_o  = owner_byte;
               byte_cnt_d = byte_cnt_q + 8'd1;
               // A length release leaves the rest of the stream for a later grant.
               if (req_last_i[owner_q] || at_max) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = next_ptr;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         byte_cnt_q <= '0;
         grant_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         grant_q    <= grant_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: lane sources driven from byte queues,
// FIFO writes captured mid-cycle and compared with hand-built expectations.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_i;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_write;
   logic           tx_full;
   logic [N-1:0]   grant;
   logic           busy;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int full_viol = 0;

   logic [8:0] lane_q [N][$];
   bit         hold [N];
   logic [7:0] wr_data [$];
   int         wr_cyc [$];
   logic [7:0] exp_q [$];

   logic [N-1:0] hs;
   logic [N-1:0] snap_grant, snap_ready;
   logic         snap_write, snap_busy;
   logic [7:0]   snap_data;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ     (N),
      .HEADER_EN   (1),
      .MAX_PKT_LEN (4)
   ) dut (
      .clock_i     (clk),
      .reset_i     (reset_i),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .tx_data_o   (tx_data),
      .tx_write_o  (tx_write),
      .tx_full_i   (tx_full),
      .grant_o     (grant),
      .busy_o      (busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_write === 1'b1) begin
         wr_data.push_back(tx_data);
         wr_cyc.push_back(cyc);
      end
      if (tx_write === 1'b1 && tx_full === 1'b1) full_viol++;
   end

   task automatic drive_lanes();
      for (int k = 0; k < N; k++) begin
         if (!hold[k] && lane_q[k].size() != 0) begin
            req_valid[k]       = 1'b1;
            req_data[8*k +: 8] = lane_q[k][0][7:0];
            req_last[k]        = lane_q[k][0][8];
         end else begin
            req_valid[k]       = 1'b0;
            req_data[8*k +: 8] = 8'h00;
            req_last[k]        = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      hs         = req_valid & req_ready;
      snap_grant = grant;
      snap_ready = req_ready;
      snap_write = tx_write;
      snap_busy  = busy;
      snap_data  = tx_data;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
         if (hs[k] && lane_q[k].size() > 0) void'(lane_q[k].pop_front());
      drive_lanes();
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tx_full = 1'b0;
      for (int k = 0; k < N; k++) begin
         lane_q[k].delete();
         hold[k] = 1'b0;
      end
      drive_lanes();
      tick();
      tick();
      reset_i = 1'b0;
      drive_lanes();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (snap_grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", snap_grant); end
      checks++;
      if (snap_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", snap_busy); end
      checks++;
      if (snap_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", snap_ready); end
      checks++;
      if (snap_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", snap_write); end
      checks++;
      if (snap_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", snap_data); end
   endtask

   task automatic test_single();
      int t0;
      wr_data.delete();
      wr_cyc.delete();
      lane_q[0].push_back(9'h011);
      lane_q[0].push_back(9'h022);
      lane_q[0].push_back(9'h133);
      drive_lanes();
      t0 = cyc;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 2) begin
            checks++;
            if (snap_grant !== 4'b0001) begin failures++; $display("FAIL single_grant_hdr got=%b exp=0001", snap_grant); end
         end
         if (i == 6) begin
            checks++;
            if (snap_grant !== 4'b0000) begin failures++; $display("FAIL single_grant_release got=%b exp=0000", snap_grant); end
            checks++;
            if (snap_busy !== 1'b0) begin failures++; $display("FAIL single_busy_release got=%b exp=0", snap_busy); end
         end
      end
      exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
      checks++;
      if (wr_data.size() != exp_q.size()) begin failures++; $display("FAIL single_len got=%0d exp=%0d", wr_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (i >= wr_data.size() || wr_data[i] !== exp_q[i] || wr_cyc[i] != t0 + 1 + i) begin
            failures++;
            $display("FAIL single_byte%0d got=%h@%0d exp=%h@%0d", i,
                     (i < wr_data.size()) ? wr_data[i] : 8'hxx, (i < wr_cyc.size()) ? wr_cyc[i] : -1,
                     exp_q[i], t0 + 1 + i);
         end
      end
   endtask

   task automatic test_round_robin();
      wr_data.delete();
      lane_q[0].push_back(9'h144);
      lane_q[1].push_back(9'h155);
      drive_lanes();
      repeat (8) tick();
      exp_q = '{8'hA1, 8'h55, 8'hA0, 8'h44};
      checks++;
      if (wr_data.size() != exp_q.size()) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", wr_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (i >= wr_data.size() || wr_data[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL rr_byte%0d got=%h exp=%h", i, (i < wr_data.size()) ? wr_data[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_fairness();
      do_reset();
      lane_q[0] = '{9'h001, 9'h102, 9'h003, 9'h104};
      lane_q[1] = '{9'h011, 9'h112, 9'h013, 9'h114};
      lane_q[3] = '{9'h031, 9'h132, 9'h033, 9'h134};
      drive_lanes();
      repeat (30) tick();
      exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA3, 8'h31, 8'h32,
                8'hA0, 8'h03, 8'h04, 8'hA1, 8'h13, 8'h14, 8'hA3, 8'h33, 8'h34};
      checks++;
      if (wr_data.size() != exp_q.size()) begin failures++; $display("FAIL fair_len got=%0d exp=%0d", wr_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (i >= wr_data.size() || wr_data[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL fair_byte%0d got=%h exp=%h", i, (i < wr_data.size()) ? wr_data[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      wr_data.delete();
      lane_q[2] = '{9'h021, 9'h022, 9'h023, 9'h124};
      drive_lanes();
      repeat (4) tick();
      tx_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (snap_write !== 1'b0 || snap_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_stall%0d got=write:%b ready:%b exp=write:0 ready:0000", i, snap_write, snap_ready);
         end
      end
      tx_full = 1'b0;
      repeat (4) tick();
      exp_q = '{8'hA2, 8'h21, 8'h22, 8'h23, 8'h24};
      checks++;
      if (wr_data.size() != exp_q.size()) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", wr_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (i >= wr_data.size() || wr_data[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL bp_byte%0d got=%h exp=%h", i, (i < wr_data.size()) ? wr_data[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_truncation();
      do_reset();
      lane_q[2] = '{9'h061, 9'h062, 9'h063, 9'h064, 9'h065, 9'h166};
      drive_lanes();
      tick();
      lane_q[1] = '{9'h071, 9'h172};
      drive_lanes();
      repeat (18) tick();
      exp_q = '{8'hA2, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA1, 8'h71, 8'h72, 8'hA2, 8'h65, 8'h66};
      checks++;
      if (wr_data.size() != exp_q.size()) begin failures++; $display("FAIL trunc_len got=%0d exp=%0d", wr_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (i >= wr_data.size() || wr_data[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL trunc_byte%0d got=%h exp=%h", i, (i < wr_data.size()) ? wr_data[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_owner_stall();
      do_reset();
      lane_q[0] = '{9'h081, 9'h082, 9'h183};
      lane_q[1] = '{9'h191};
      drive_lanes();
      repeat (3) tick();
      hold[0] = 1'b1;
      drive_lanes();
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (snap_grant !== 4'b0001 || snap_ready[1] !== 1'b0 || snap_write !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d got=grant:%b ready1:%b write:%b exp=grant:0001 ready1:0 write:0",
                     i, snap_grant, snap_ready[1], snap_write);
         end
      end
      hold[0] = 1'b0;
      drive_lanes();
      repeat (8) tick();
      exp_q = '{8'hA0, 8'h81, 8'h82, 8'h83, 8'hA1, 8'h91};
      checks++;
      if (wr_data.size() != exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", wr_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (i >= wr_data.size() || wr_data[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL stall_byte%0d got=%h exp=%h", i, (i < wr_data.size()) ? wr_data[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      wr_data.delete();
      lane_q[0] = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4, 9'h1C5};
      drive_lanes();
      repeat (4) tick();
      reset_i = 1'b1;
      for (int k = 0; k < N; k++) lane_q[k].delete();
      drive_lanes();
      tick();
      reset_i = 1'b0;
      drive_lanes();
      tick();
      checks++;
      if (snap_grant !== 4'b0000 || snap_busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_ctrl got=grant:%b busy:%b exp=grant:0000 busy:0", snap_grant, snap_busy);
      end
      checks++;
      if (snap_ready !== 4'b0000 || snap_write !== 1'b0 || snap_data !== 8'h00) begin
         failures++;
         $display("FAIL midrst_out got=ready:%b write:%b data:%h exp=ready:0000 write:0 data:00",
                  snap_ready, snap_write, snap_data);
      end
      lane_q[3].push_back(9'h1D3);
      drive_lanes();
      repeat (5) tick();
      exp_q = '{8'hA0, 8'hC1, 8'hC2, 8'hA3, 8'hD3};
      checks++;
      if (wr_data.size() != exp_q.size()) begin failures++; $display("FAIL midrst_len got=%0d exp=%0d", wr_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (i >= wr_data.size() || wr_data[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL midrst_byte%0d got=%h exp=%h", i, (i < wr_data.size()) ? wr_data[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   initial begin
      reset_i   = 1'b1;
      tx_full   = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_backpressure();
      test_truncation();
      test_owner_stall();
      test_reset_mid();
      checks++;
      if (full_viol != 0) begin failures++; $display("FAIL write_while_full got=%0d exp=0", full_viol); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
